nibble_demux4: RTL and testbench

NIBBLE_DEMUX4 -- requirements
Module: nibble_demux4

---
 rtl/nibble_demux4.sv | 114 +++++++++++
 tb/tb_nibble_demux4.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_demux4.sv
// Collects four WIDTH-bit words addressed by select into shadow slots and
// publishes them atomically on q0..q3 once every slot of the frame is written.
module nibble_demux4 #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       select,
    input  logic             din_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             dup_err
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [3:0]       mask, mask_n, slot;
    logic [15:0]      idle_cnt, idle_n;
    logic [WIDTH-1:0] shadow [4];
    logic [WIDTH-1:0] frame  [4];
    logic             accept, commit, done_n, abort_n, dup_n;

    always_comb begin
        slot    = 4'b0001 << select;
        accept  = din_valid && !clear;
        state_n = state;
        mask_n  = mask;
        idle_n  = idle_cnt;
        commit  = 1'b0;
        done_n  = 1'b0;
        abort_n = 1'b0;
        dup_n   = dup_err;
        // The committed frame must include the word arriving on the commit edge.
        for (int unsigned i = 0; i < 4; i++) begin
            frame[i] = (accept && select == 2'(i)) ? din : shadow[i];
        end
        case (state)
            IDLE: begin
                idle_n = '0;
                if (accept) begin
                    mask_n  = slot;
                    state_n = FILL;
                end
            end
            FILL: begin
                if (clear) begin
                    mask_n  = '0;
                    idle_n  = '0;
                    state_n = IDLE;
                end else if (din_valid) begin
                    idle_n = '0;
                    if ((mask & slot) != '0) dup_n = 1'b1;
                    if ((mask | slot) == 4'hF) begin
                        commit  = 1'b1;
                        done_n  = 1'b1;
                        mask_n  = '0;
                        state_n = IDLE;
                    end else begin
                        mask_n = mask | slot;
                    end
                end else if (idle_cnt == TO_LAST) begin
                    // This idle edge would bring the count to TIMEOUT: discard.
                    abort_n = 1'b1;
                    mask_n  = '0;
                    idle_n  = '0;
                    state_n = IDLE;
                end else begin
                    idle_n = idle_cnt + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '0;
            idle_cnt    <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            dup_err     <= 1'b0;
            q0          <= '0;
            q1          <= '0;
            q2          <= '0;
            q3          <= '0;
            for (int unsigned i = 0; i < 4; i++) shadow[i] <= '0;
        end else begin
            state       <= state_n;
            mask        <= mask_n;
            idle_cnt    <= idle_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
            dup_err     <= dup_n;
            if (accept) shadow[select] <= din;
            if (commit) begin
                q0 <= frame[0];
                q1 <= frame[1];
                q2 <= frame[2];
                q3 <= frame[3];
            end
        end
    end

endmodule

// File: tb/tb_nibble_demux4.sv
// Bench for nibble_demux4: directed scenarios plus random traffic, all checked
// every cycle against a slot-fill model of the frame collector.
module tb_nibble_demux4;

    localparam int W  = 4;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic [1:0]   select = '0;
    logic         din_valid = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] q0, q1, q2, q3;
    logic         frame_done, frame_abort, dup_err;

    int n_cmp = 0;
    int n_bad = 0;

    nibble_demux4 #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .select(select),
        .din_valid(din_valid), .clear(clear),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .frame_done(frame_done), .frame_abort(frame_abort), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    // Reference: which slots hold a word, how long the frame has sat idle,
    // and the last published frame.
    logic [W-1:0] m_sh [4] = '{default: '0};
    bit           m_filled [4] = '{default: 0};
    int           m_idle = 0;
    logic [W-1:0] m_q [4] = '{default: '0};
    bit           m_done = 0, m_abort = 0, m_dup = 0;

    function automatic int filled_count();
        int c = 0;
        for (int i = 0; i < 4; i++) c += m_filled[i] ? 1 : 0;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_sh[i] = '0; m_filled[i] = 0; m_q[i] = '0;
            end
            m_idle = 0; m_done = 0; m_abort = 0; m_dup = 0;
        end else begin
            m_done = 0;
            m_abort = 0;
            if (clear) begin
                for (int i = 0; i < 4; i++) m_filled[i] = 0;
                m_idle = 0;
            end else if (din_valid) begin
                if (m_filled[select]) m_dup = 1;
                m_sh[select] = din;
                m_filled[select] = 1;
                m_idle = 0;
                if (filled_count() == 4) begin
                    for (int i = 0; i < 4; i++) begin
                        m_q[i] = m_sh[i]; m_filled[i] = 0;
                    end
                    m_done = 1;
                end
            end else if (filled_count() > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    for (int i = 0; i < 4; i++) m_filled[i] = 0;
                    m_idle = 0;
                    m_abort = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("q0", int'(q0), int'(m_q[0]));
        chk("q1", int'(q1), int'(m_q[1]));
        chk("q2", int'(q2), int'(m_q[2]));
        chk("q3", int'(q3), int'(m_q[3]));
        chk("frame_done", int'(frame_done), int'(m_done));
        chk("frame_abort", int'(frame_abort), int'(m_abort));
        chk("dup_err", int'(dup_err), int'(m_dup));
    end

    task automatic wr(input logic [1:0] s, input logic [W-1:0] d);
        @(negedge clk);
        din_valid = 1'b1; clear = 1'b0; select = s; din = d;
    endtask

    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic chk_q(input string name, input int a, input int b, input int c, input int d);
        chk({name, "_q0"}, int'(q0), a);
        chk({name, "_q1"}, int'(q1), b);
        chk({name, "_q2"}, int'(q2), c);
        chk({name, "_q3"}, int'(q3), d);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_q("rst", 0, 0, 0, 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_dup", int'(dup_err), 0);
        rst_n = 1'b1;

        // Basic in-order frame
        wr(0, 1); wr(1, 2); wr(2, 4);
        @(negedge clk); chk_q("pre", 0, 0, 0, 0); din_valid = 1'b1; select = 3; din = 8;
        @(negedge clk); chk_q("f1", 1, 2, 4, 8); chk("f1_done", int'(frame_done), 1);
        din_valid = 1'b0;
        @(negedge clk); chk("f1_done_pulse", int'(frame_done), 0);

        // Out-of-order frame
        wr(3, 4'hA); wr(1, 4'hB); wr(0, 4'hC); wr(2, 4'hD);
        idle();
        chk_q("f2", 12, 11, 13, 10);

        // Duplicate write
        wr(0, 5); wr(0, 6); wr(1, 7); wr(2, 9); wr(3, 3);
        idle();
        chk_q("f3", 6, 7, 9, 3);
        chk("f3_dup", int'(dup_err), 1);

        // Timeout discard
        wr(0, 15); idle(); idle(); idle();
        @(negedge clk); chk("to_early", int'(frame_abort), 0); din_valid = 1'b0;
        @(negedge clk); chk("to_abort", int'(frame_abort), 1); chk_q("to_hold", 6, 7, 9, 3);
        wr(0, 1); wr(1, 3); wr(2, 5); wr(3, 7);
        idle();
        chk_q("f4", 1, 3, 5, 7);

        // Clear beats a simultaneous write
        wr(0, 2); wr(1, 2); wr(2, 2);
        @(negedge clk); din_valid = 1'b1; clear = 1'b1; select = 3; din = 2;
        @(negedge clk); chk("clr_done", int'(frame_done), 0); din_valid = 1'b0; clear = 1'b0;
        wr(0, 9); wr(1, 8); wr(2, 7); wr(3, 6);
        idle();
        chk_q("f5", 9, 8, 7, 6);
        chk("f5_done", int'(frame_done), 1);

        // Asynchronous reset mid-frame
        wr(0, 4); wr(1, 4); wr(2, 4);
        @(negedge clk); din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_q("arst", 0, 0, 0, 0); chk("arst_dup", int'(dup_err), 0);
        @(negedge clk); rst_n = 1'b1;
        wr(3, 1); wr(2, 2); wr(1, 3); wr(0, 4);
        idle();
        chk_q("f6", 4, 3, 2, 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            int pv = ((i / 500) % 2 == 0) ? 70 : 15;
            @(negedge clk);
            rst_n     = (r >= 1);
            din_valid = ($urandom_range(0, 99) < pv);
            clear     = ($urandom_range(0, 99) < 3);
            select    = 2'($urandom_range(0, 3));
            din       = W'($urandom);
        end
        @(negedge clk); rst_n = 1'b1; din_valid = 1'b0; clear = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
